multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the multicycle CPU datapath around the shared instruction/data memory.
//  Fetches through the instruction decoder's memory, classifies OP/FUNCT, and drives all datapath enables/selects per phase.
//  Counts retired instructions, and halts on an unsupported encoding.
//  Sits between the instruction decoder fields and the register file, ALU, PC and memory write port.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter
// PORTS
//  Clk        in   1   clock, all state updates on rising edge
//  Reset      in   1   asynchronous, active-high; forces IDLE and output reset values
//  start      in   1   in IDLE, begin fetching at current PC; ignored in all other states
//  stop_req   in   1   sampled in each instruction's last state; 1 -> IDLE instead of FETCH
//  OP         in   6   opcode field from instruction decoder (valid from DECODE onward)
//  FUNCT      in   6   funct field from instruction decoder
//  zero       in   1   ALU zero flag (A==B compare in EXEC)
//  PCWE       out  1   PC register write enable
//  IRWE       out  1   instruction register write enable
//  IorD       out  1   memory address select: 0=PC, 1=ALUOut
//  MemWE      out  1   data memory write (drives memory regWE)
//  RegWE      out  1   register file write enable
//  ALUSrcA    out  1   0=PC, 1=A reg
//  ALUSrcB    out  2   0=B reg, 1=const 4, 2=sign-ext IMM16, 3=sign-ext IMM16<<2
//  ALUOp      out  3   ALU_ADD/ALU_SUB/ALU_XOR/ALU_SLT
//  PCSrc      out  2   0=ALU result, 1=ALUOut, 2={PC[31:28],TA,2'b00}, 3=A reg
//  RegDst     out  2   0=RT, 1=RD, 2=5'd31
//  MemToReg   out  2   0=ALUOut, 1=MDR, 2=PC
//  busy       out  1   1 in every state except IDLE and HALT
//  illegal    out  1   sticky; set on entry to HALT, cleared only by Reset
//  instr_cnt  out  CNT_W  retired instructions; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE, all enables 0, all selects 0, busy=0, illegal=0, instr_cnt=0.
//  All outputs are Moore (function of state and latched class only). OP/FUNCT are never used combinationally to outputs.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//  IDLE   : start -> FETCH.
//  FETCH  : IorD=0, IRWE=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSrc=0, PCWE=1 (PC<=PC+4). Next state is DECODE.
//  DECODE : latch class from OP/FUNCT. ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target -> ALUOut).
//           Unsupported -> HALT. Otherwise -> EXEC.
//  Classes/opcodes: RTYPE OP=00 with FUNCT ADD=20 SUB=22 SLT=2A; JR OP=00 FUNCT=08; LW=23; SW=2B;
//           ADDI=08; XORI=0E; BEQ=04; BNE=05; J=02; JAL=03. Any other OP/FUNCT is unsupported.
//  EXEC   : RTYPE: A op B. ADDI/LW/SW: A+imm. XORI: A^zero-ext imm (ALUSrcB=2, ext done in datapath).
//           BEQ/BNE: ALUOp=SUB; PCWE=zero (BEQ) or !zero (BNE), PCSrc=1.
//           J: PCWE=1, PCSrc=2. JAL: PCWE=1, PCSrc=2, RegWE=1, RegDst=2, MemToReg=2 (PC already +4).
//           JR: PCWE=1, PCSrc=3.
//           Next state: LW/SW -> MEM; RTYPE/ADDI/XORI -> WB; others retire.
//  MEM    : IorD=1. SW: MemWE=1, retire. LW: MDR loads -> WB.
//  WB     : RegWE=1. RTYPE: RegDst=1, MemToReg=0. ADDI/XORI: RegDst=0, MemToReg=0. LW: RegDst=0, MemToReg=1. Retire.
//  Retire : instr_cnt+1 in the same cycle. Next state is FETCH, or IDLE if stop_req=1 in that cycle.
//  Latency in cycles: J/JAL/JR/BEQ/BNE=3, RTYPE/ADDI/XORI/SW=4, LW=5.
//  HALT   : absorbing; all enables 0, illegal=1; start ignored; instr_cnt frozen (illegal not counted).
//  Reset mid-instruction: immediate IDLE; no partial write is completed (enables drop asynchronously).
//  Counter wrap: all-ones + retire -> 0, no flag.
//  start and stop_req both high in IDLE: go to FETCH; stop_req only matters at retire.
// STRUCTURE
//  Include file cpu_defines.vh: opcode/funct constants, ALU_ADD=0 ALU_SUB=1 ALU_XOR=2 ALU_SLT=3,
//    state encodings, class encodings, select encodings above.
//  Sub-module op_classify: combinational OP/FUNCT -> {class[3:0], legal}; FSM registers its output in DECODE.
// TESTING
//  1 Reset high mid-EXEC of ADD -> next sample: IDLE, RegWE=0, PCWE=0, busy=0, instr_cnt=0.
//  2 start; ADD (OP=00, FUNCT=20) -> states FETCH,DECODE,EXEC,WB; RegWE=1 only in WB with RegDst=1; instr_cnt=1.
//  3 LW (OP=23) then SW (OP=2B) -> LW takes 5 cycles, MemToReg=1 in WB; SW MemWE=1 only in MEM, IorD=1; instr_cnt=2.
//  4 BNE with zero=1 -> PCWE=0 in EXEC; same BNE with zero=0 -> PCWE=1, PCSrc=1; each takes 3 cycles.
//  5 JAL (OP=03) -> EXEC: PCWE=1, PCSrc=2, RegWE=1, RegDst=2, MemToReg=2. stop_req=1 then -> IDLE, busy=0.
//  6 OP=3F -> HALT after DECODE, illegal=1, start ignored, instr_cnt unchanged. CNT_W=4 at 15 + retire -> 0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_pkg
// Description : Shared encodings for the multicycle CPU controller: opcode and
//               funct constants, ALU operation codes, datapath select codes,
//               FSM state encoding and instruction class encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field values (only meaningful when OP == OP_RTYPE)
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_X4 = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    // Register destination select
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // Register write-back source select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // R-type arithmetic is split into one class per funct so that the ALU
    // operation is fully determined by the latched class.
    typedef enum logic [3:0] {
        CLS_ADD  = 4'd0,
        CLS_SUB  = 4'd1,
        CLS_SLT  = 4'd2,
        CLS_JR   = 4'd3,
        CLS_LW   = 4'd4,
        CLS_SW   = 4'd5,
        CLS_ADDI = 4'd6,
        CLS_XORI = 4'd7,
        CLS_BEQ  = 4'd8,
        CLS_BNE  = 4'd9,
        CLS_J    = 4'd10,
        CLS_JAL  = 4'd11
    } class_e;

    // ALU operation used by an R-type arithmetic class in EXEC
    function automatic logic [2:0] rtype_aluop(input class_e cls);
        logic [2:0] op;
        op = ALU_ADD;
        case (cls)
            CLS_SUB: op = ALU_SUB;
            CLS_SLT: op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage : multicycle_controller_pkg
`default_nettype wire

// File: rtl/multicycle_controller_op_classify.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_op_classify
// Description : Combinational instruction classifier. Maps the decoder's
//               OP/FUNCT fields to an instruction class and a legal flag.
// Ports       : op_i     [5:0]  opcode field
//               funct_i  [5:0]  funct field
//               cls_o    [3:0]  instruction class (valid when legal_o=1)
//               legal_o         1 when the encoding is supported
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller_op_classify
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output class_e     cls_o,
    output logic       legal_o
);

    always_comb begin
        cls_o   = CLS_ADD;
        legal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  begin cls_o = CLS_ADD; legal_o = 1'b1; end
                    FN_SUB:  begin cls_o = CLS_SUB; legal_o = 1'b1; end
                    FN_SLT:  begin cls_o = CLS_SLT; legal_o = 1'b1; end
                    FN_JR:   begin cls_o = CLS_JR;  legal_o = 1'b1; end
                    default: ;
                endcase
            end
            OP_LW:   begin cls_o = CLS_LW;   legal_o = 1'b1; end
            OP_SW:   begin cls_o = CLS_SW;   legal_o = 1'b1; end
            OP_ADDI: begin cls_o = CLS_ADDI; legal_o = 1'b1; end
            OP_XORI: begin cls_o = CLS_XORI; legal_o = 1'b1; end
            OP_BEQ:  begin cls_o = CLS_BEQ;  legal_o = 1'b1; end
            OP_BNE:  begin cls_o = CLS_BNE;  legal_o = 1'b1; end
            OP_J:    begin cls_o = CLS_J;    legal_o = 1'b1; end
            OP_JAL:  begin cls_o = CLS_JAL;  legal_o = 1'b1; end
            default: ;
        endcase
    end

endmodule : multicycle_controller_op_classify
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore FSM sequencing the multicycle CPU datapath through
//               FETCH/DECODE/EXEC/MEM/WB, counting retired instructions and
//               halting on an unsupported encoding.
// Ports       : Clk, Reset           clock / async active-high reset
//               start, stop_req      run control
//               OP, FUNCT, zero      decoder fields and ALU zero flag
//               PCWE..MemToReg       datapath enables and selects
//               busy, illegal        status
//               instr_cnt [CNT_W]    retired instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             stop_req,
    input  logic [5:0]       OP,
    input  logic [5:0]       FUNCT,
    input  logic             zero,
    output logic             PCWE,
    output logic             IRWE,
    output logic             IorD,
    output logic             MemWE,
    output logic             RegWE,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemToReg,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    class_e           cls_q, cls_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    class_e           cls_w;
    logic             legal_w;
    logic             retire_w;

    multicycle_controller_op_classify u_classify (
        .op_i    (OP),
        .funct_i (FUNCT),
        .cls_o   (cls_w),
        .legal_o (legal_w)
    );

    // ------------------------------------------------------------------
    // State register. Reset is asynchronous so every enable (all decoded
    // from state_q) drops immediately, abandoning any in-flight write.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_ADD;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode. Outputs depend only on state_q and the
    // latched class (plus the ALU zero flag for conditional branches).
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        retire_w = 1'b0;

        PCWE     = 1'b0;
        IRWE     = 1'b0;
        IorD     = 1'b0;
        MemWE    = 1'b0;
        RegWE    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALU_ADD;
        PCSrc    = PCSRC_ALU;
        RegDst   = REGDST_RT;
        MemToReg = M2R_ALUOUT;
        busy     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                busy    = 1'b1;
                IRWE    = 1'b1;
                ALUSrcB = SRCB_FOUR;
                PCWE    = 1'b1;
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                busy    = 1'b1;
                ALUSrcB = SRCB_IMM_X4;
                if (legal_w) begin
                    cls_d   = cls_w;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_HALT;
                end
            end

            ST_EXEC: begin
                busy = 1'b1;
                case (cls_q)
                    CLS_ADD, CLS_SUB, CLS_SLT: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = SRCB_B;
                        ALUOp   = rtype_aluop(cls_q);
                        state_d = ST_WB;
                    end
                    CLS_ADDI: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = SRCB_IMM;
                        state_d = ST_WB;
                    end
                    CLS_XORI: begin
                        // Zero extension of the immediate happens in the datapath.
                        ALUSrcA = 1'b1;
                        ALUSrcB = SRCB_IMM;
                        ALUOp   = ALU_XOR;
                        state_d = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = SRCB_IMM;
                        state_d = ST_MEM;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        ALUSrcA  = 1'b1;
                        ALUSrcB  = SRCB_B;
                        ALUOp    = ALU_SUB;
                        PCSrc    = PCSRC_ALUOUT;
                        PCWE     = (cls_q == CLS_BEQ) ? zero : ~zero;
                        retire_w = 1'b1;
                    end
                    CLS_J: begin
                        PCWE     = 1'b1;
                        PCSrc    = PCSRC_JUMP;
                        retire_w = 1'b1;
                    end
                    CLS_JAL: begin
                        // PC already holds the return address (PC+4 from FETCH).
                        PCWE     = 1'b1;
                        PCSrc    = PCSRC_JUMP;
                        RegWE    = 1'b1;
                        RegDst   = REGDST_RA;
                        MemToReg = M2R_PC;
                        retire_w = 1'b1;
                    end
                    CLS_JR: begin
                        PCWE     = 1'b1;
                        PCSrc    = PCSRC_REG;
                        retire_w = 1'b1;
                    end
                    default: begin
                        retire_w = 1'b1;
                    end
                endcase
            end

            ST_MEM: begin
                busy = 1'b1;
                IorD = 1'b1;
                if (cls_q == CLS_SW) begin
                    MemWE    = 1'b1;
                    retire_w = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_WB: begin
                busy     = 1'b1;
                RegWE    = 1'b1;
                retire_w = 1'b1;
                case (cls_q)
                    CLS_ADD, CLS_SUB, CLS_SLT: RegDst   = REGDST_RD;
                    CLS_LW:                    MemToReg = M2R_MDR;
                    default: ;
                endcase
            end

            ST_HALT: begin
                // Absorbing: only Reset leaves this state.
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retire_w) begin
            state_d = stop_req ? ST_IDLE : ST_FETCH;
        end
    end

    assign illegal_d = illegal_q | (state_d == ST_HALT);
    assign cnt_d     = retire_w ? (cnt_q + CNT_W'(1)) : cnt_q;

    assign illegal   = illegal_q;
    assign instr_cnt = cnt_q;

endmodule : multicycle_controller
`default_nettype wire
